// File: rtl/handshake_monitor.sv
// handshake_monitor
//   Passive checker for N_CHANNELS independent valid/ready channels. It
//   counts completed transfers and raises sticky error flags for protocol
//   violations seen while a transfer is pending (valid high, ready low).
//
// Parameters
//   N_CHANNELS   number of monitored channels
//   DATA_WIDTH   payload width per channel
//   STALL_LIMIT  consecutive stalled edges that raise err_stall (1..255)
//   CNT_WIDTH    width of each per-channel transfer counter
//
// Ports
//   CLK              clock, rising edge
//   RESET            synchronous active-high reset (wins over everything)
//   valid, ready     per-channel handshake
//   data             per-channel payload, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   err_clr          synchronous clear of all sticky flags
//   xfer_count       per-channel transfer count, packed like data
//   err_valid_drop   valid deasserted while pending
//   err_data_change  payload changed while pending
//   err_stall        pending for STALL_LIMIT consecutive edges
//   any_err          OR of all error flags
//
// Build option
//   HANDSHAKE_MONITOR_ASSERT_EN  adds concurrent assertions that fire on
//   each violation condition; flag/counter behaviour is unchanged.
module handshake_monitor #(
  parameter int N_CHANNELS  = 3,
  parameter int DATA_WIDTH  = 4,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [N_CHANNELS-1:0]            valid,
  input  logic [N_CHANNELS-1:0]            ready,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] data,
  input  logic                             err_clr,
  output logic [N_CHANNELS*CNT_WIDTH-1:0]  xfer_count,
  output logic [N_CHANNELS-1:0]            err_valid_drop,
  output logic [N_CHANNELS-1:0]            err_data_change,
  output logic [N_CHANNELS-1:0]            err_stall,
  output logic                             any_err
);

  localparam logic [7:0] LIMIT    = 8'(STALL_LIMIT);
  localparam logic [7:0] LIMIT_M1 = 8'(STALL_LIMIT - 1);

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    logic                  v;
    logic                  r;
    logic [DATA_WIDTH-1:0] d;
    logic                  pend;
    logic [DATA_WIDTH-1:0] shadow;
    logic [7:0]            stall_cnt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  f_drop;
    logic                  f_chg;
    logic                  f_stall;
    logic                  drop_ev;
    logic                  chg_ev;
    logic                  stall_ev;

    assign v = valid[i];
    assign r = ready[i];
    assign d = data[i*DATA_WIDTH +: DATA_WIDTH];

    // The stall counter counts every valid&!ready edge, including the one
    // that opens the episode, so err_stall fires on the STALL_LIMIT-th
    // stalled edge. Saturation at LIMIT keeps the event one-shot.
    always_comb begin
      drop_ev  = pend & ~v;
      chg_ev   = pend & v & (d != shadow);
      stall_ev = v & ~r & (stall_cnt == LIMIT_M1);
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        pend      <= 1'b0;
        shadow    <= '0;
        stall_cnt <= '0;
        cnt       <= '0;
        f_drop    <= 1'b0;
        f_chg     <= 1'b0;
        f_stall   <= 1'b0;
      end else begin
        pend <= v & ~r;
        if (~pend & v & ~r)
          shadow <= d;
        if (v & ~r) begin
          if (stall_cnt != LIMIT)
            stall_cnt <= stall_cnt + 8'd1;
        end else begin
          stall_cnt <= '0;
        end
        if (v & r)
          cnt <= cnt + CNT_WIDTH'(1);
        // A violation on the clearing edge survives the clear.
        f_drop  <= (f_drop  & ~err_clr) | drop_ev;
        f_chg   <= (f_chg   & ~err_clr) | chg_ev;
        f_stall <= (f_stall & ~err_clr) | stall_ev;
      end
    end

    assign xfer_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
    assign err_valid_drop[i]  = f_drop;
    assign err_data_change[i] = f_chg;
    assign err_stall[i]       = f_stall;

`ifdef HANDSHAKE_MONITOR_ASSERT_EN
    a_valid_drop: assert property (@(posedge CLK) disable iff (RESET) !drop_ev);
    a_data_change: assert property (@(posedge CLK) disable iff (RESET) !chg_ev);
    a_stall: assert property (@(posedge CLK) disable iff (RESET) !stall_ev);
`else
`endif
  end

  assign any_err = |{err_valid_drop, err_data_change, err_stall};

endmodule

// File: tb/tb_handshake_monitor.sv
module tb_handshake_monitor;

  localparam int N  = 3;
  localparam int DW = 4;
  localparam int CW = 8;
  localparam int SL = 4;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic [N*DW-1:0] data;
  logic            err_clr;
  logic [N*CW-1:0] xfer_count;
  logic [N-1:0]    err_valid_drop;
  logic [N-1:0]    err_data_change;
  logic [N-1:0]    err_stall;
  logic            any_err;

  handshake_monitor #(
    .N_CHANNELS (N),
    .DATA_WIDTH (DW),
    .STALL_LIMIT(SL),
    .CNT_WIDTH  (CW)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .valid          (valid),
    .ready          (ready),
    .data           (data),
    .err_clr        (err_clr),
    .xfer_count     (xfer_count),
    .err_valid_drop (err_valid_drop),
    .err_data_change(err_data_change),
    .err_stall      (err_stall),
    .any_err        (any_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: per-channel behavioural bookkeeping.
  bit          m_pend  [N];
  int unsigned m_hold  [N];
  int unsigned m_age   [N];
  int unsigned m_cnt   [N];
  bit          m_drop  [N];
  bit          m_chg   [N];
  bit          m_stall [N];

  task automatic model_step(input logic [N-1:0] v, r, input logic [N*DW-1:0] d,
                            input logic clr, rst);
    for (int c = 0; c < N; c++) begin
      int unsigned dv;
      bit nd, nc, ns;
      dv = int'(d[c*DW +: DW]);
      if (rst) begin
        m_pend[c] = 0; m_hold[c] = 0; m_age[c] = 0; m_cnt[c] = 0;
        m_drop[c] = 0; m_chg[c] = 0; m_stall[c] = 0;
      end else begin
        nd = m_pend[c] && !v[c];
        nc = m_pend[c] && v[c] && (dv != m_hold[c]);
        ns = 0;
        if (v[c] && !r[c]) begin
          m_age[c]++;
          ns = (m_age[c] == SL);
        end else begin
          m_age[c] = 0;
        end
        if (v[c] && r[c]) m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
        if (!m_pend[c] && v[c] && !r[c]) m_hold[c] = dv;
        m_pend[c]  = v[c] && !r[c];
        m_drop[c]  = (m_drop[c]  && !clr) || nd;
        m_chg[c]   = (m_chg[c]   && !clr) || nc;
        m_stall[c] = (m_stall[c] && !clr) || ns;
      end
    end
  endtask

  task automatic compare_model();
    logic [N*CW-1:0] ec;
    logic [N-1:0] ed, eg, es;
    for (int c = 0; c < N; c++) begin
      ec[c*CW +: CW] = CW'(m_cnt[c]);
      ed[c] = m_drop[c];
      eg[c] = m_chg[c];
      es[c] = m_stall[c];
    end
    chk("model_xfer_count", 64'(xfer_count), 64'(ec));
    chk("model_err_valid_drop", 64'(err_valid_drop), 64'(ed));
    chk("model_err_data_change", 64'(err_data_change), 64'(eg));
    chk("model_err_stall", 64'(err_stall), 64'(es));
    chk("model_any_err", 64'(any_err), 64'(|{ed, eg, es}));
  endtask

  task automatic tick(input logic [N-1:0] v, r, input logic [N*DW-1:0] d,
                      input logic clr, rst);
    valid = v; ready = r; data = d; err_clr = clr; RESET = rst;
    @(posedge CLK);
    model_step(v, r, d, clr, rst);
    @(negedge CLK);
    compare_model();
  endtask

  typedef struct {
    logic [N-1:0]    v;
    logic [N-1:0]    r;
    logic [N*DW-1:0] d;
    logic            clr;
    logic            rst;
    logic [N-1:0]    e_drop;
    logic [N-1:0]    e_chg;
    logic [N-1:0]    e_stall;
  } vec_t;

  vec_t tbl[$];

  initial begin
    valid = '0; ready = '0; data = '0; err_clr = 1'b0; RESET = 1'b1;

    // Hand-checked expectations, applied after a reset.
    tbl.push_back('{3'b010, 3'b000, 12'h0A0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b010, 3'b000, 12'h0A0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b000, 3'b000, 12'h0A0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000});
    tbl.push_back('{3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000});
    tbl.push_back('{3'b000, 3'b000, 12'h000, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b100, 3'b000, 12'h300, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b100, 3'b000, 12'h400, 1'b0, 1'b0, 3'b000, 3'b100, 3'b000});
    tbl.push_back('{3'b100, 3'b100, 12'h300, 1'b0, 1'b0, 3'b000, 3'b100, 3'b000});
    tbl.push_back('{3'b000, 3'b000, 12'h000, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b101, 3'b000, 12'h000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b101, 3'b100, 12'h100, 1'b0, 1'b0, 3'b000, 3'b100, 3'b000});
    tbl.push_back('{3'b000, 3'b000, 12'h000, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000});
    tbl.push_back('{3'b000, 3'b000, 12'h000, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000});
    for (int k = 0; k < 10; k++)
      tbl.push_back('{3'b001, 3'b000, 12'h007, 1'b0, 1'b0, 3'b000, 3'b000,
                      (k >= SL - 1) ? 3'b001 : 3'b000});
    tbl.push_back('{3'b001, 3'b000, 12'h007, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000});
    tbl.push_back('{3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000});

    // Reset state
    tick('0, '0, '0, 1'b0, 1'b1);
    chk("reset_xfer_count", 64'(xfer_count), 64'd0);
    chk("reset_any_err", 64'(any_err), 64'd0);

    // Five back-to-back transfers on ch0
    for (int k = 0; k < 5; k++) tick(3'b001, 3'b001, 12'h005, 1'b0, 1'b0);
    chk("five_xfers_cnt0", 64'(xfer_count[7:0]), 64'd5);
    chk("five_xfers_no_err", 64'(any_err), 64'd0);

    // Table vectors
    tick('0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].clr, tbl[i].rst);
      chk($sformatf("tbl%0d_drop", i), 64'(err_valid_drop), 64'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_chg", i), 64'(err_data_change), 64'(tbl[i].e_chg));
      chk($sformatf("tbl%0d_stall", i), 64'(err_stall), 64'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_any", i), 64'(any_err),
          64'(|{tbl[i].e_drop, tbl[i].e_chg, tbl[i].e_stall}));
      if (i == 7) chk("ch2_xfer_after_change", 64'(xfer_count[23:16]), 64'd1);
      if (i == tbl.size() - 2) chk("reset_mid_stall_cnt", 64'(xfer_count), 64'd0);
    end

    // Counter wrap on ch1
    tick('0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 257; k++) tick(3'b010, 3'b010, 12'h000, 1'b0, 1'b0);
    chk("wrap_cnt1", 64'(xfer_count[15:8]), 64'd1);
    chk("wrap_no_err", 64'(any_err), 64'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] rv, rr;
      logic [N*DW-1:0] rd;
      for (int c = 0; c < N; c++) begin
        rv[c] = ($urandom_range(0, 3) != 0);
        rr[c] = ($urandom_range(0, 2) == 0);
        rd[c*DW +: DW] = DW'($urandom_range(0, 1));
      end
      tick(rv, rr, rd, ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/handshake_monitor.md
HANDSHAKE_MONITOR -- requirements
Module: handshake_monitor

Interface
REQ-001 The block SHALL take parameter N_CHANNELS, default 3: number of independent valid/ready channels monitored.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 4: payload width per channel.
REQ-003 The block SHALL take parameter STALL_LIMIT, default 16: number of consecutive stalled cycles that raises a stall error (legal range 1..255).
REQ-004 The block SHALL take parameter CNT_WIDTH, default 8: width of each per-channel transfer counter.
REQ-005 Port CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 Port RESET  input  1  synchronous, active-high reset.
REQ-007 Port valid  input  N_CHANNELS  per-channel producer valid.
REQ-008 Port ready  input  N_CHANNELS  per-channel consumer ready.
REQ-009 Port data  input  N_CHANNELS*DATA_WIDTH  per-channel payload; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port err_clr  input  1  synchronous clear of all sticky error flags.
REQ-011 Port xfer_count  output  N_CHANNELS*CNT_WIDTH  per-channel count of completed transfers, packed like data.
REQ-012 Port err_valid_drop  output  N_CHANNELS  sticky: valid deasserted while a transfer was pending.
REQ-013 Port err_data_change  output  N_CHANNELS  sticky: payload changed while a transfer was pending.
REQ-014 Port err_stall  output  N_CHANNELS  sticky: pending transfer exceeded STALL_LIMIT cycles.
REQ-015 Port any_err  output  1  OR of all bits of the three error vectors.

Function
REQ-016 A transfer on channel i SHALL be defined as valid[i]=1 and ready[i]=1 sampled at a rising CLK edge.
REQ-017 Each channel SHALL hold a pending bit, set on a sampled valid=1/ready=0, cleared on a transfer or on valid=0.
REQ-018 On the edge that sets pending from 0, the channel SHALL capture data[i] into a shadow register; while pending is 1 the shadow SHALL NOT update.
REQ-019 Sampled pending=1 and valid=0 SHALL set err_valid_drop[i] at that edge; the flag SHALL be visible the following cycle.
REQ-020 Sampled pending=1, valid=1 and data[i] != shadow SHALL set err_data_change[i]; this check SHALL also apply on the completing transfer cycle.
REQ-021 A per-channel stall counter SHALL increment each edge with pending=1, valid=1, ready=0; it SHALL reset to 0 on transfer or valid drop; it SHALL saturate at STALL_LIMIT.
REQ-022 The edge at which the stall counter reaches STALL_LIMIT SHALL set err_stall[i], exactly once per stall episode.
REQ-023 xfer_count[i] SHALL increment by 1 per transfer and wrap from 2^CNT_WIDTH-1 to 0 without any error indication.
REQ-024 Error flags SHALL be sticky until err_clr or RESET; err_clr SHALL clear all flags at the edge it is sampled high.
REQ-025 When err_clr and a new violation on the same channel coincide, the new violation SHALL win and the flag SHALL be 1 afterwards.
REQ-026 Channels SHALL be fully independent; simultaneous events on different channels SHALL each be recorded.
REQ-027 any_err SHALL be combinational from the registered flags (zero added latency).
REQ-028 The block SHALL be observation-only: it SHALL drive no signal back into the monitored design.

Reset
REQ-029 With RESET high at an edge, all pending bits, shadows, stall counters, xfer_count and error flags SHALL become 0; any_err SHALL be 0.
REQ-030 RESET SHALL take priority over err_clr and over every event sampled on the same edge.
REQ-031 A transfer pending when RESET asserts SHALL be discarded; the first cycle after reset SHALL NOT report a valid drop or data change for it.

Configuration
REQ-032 With macro HANDSHAKE_MONITOR_ASSERT_EN defined, the block SHALL additionally contain concurrent assertions on CLK, disabled while RESET is high, that fail on each condition of REQ-019, REQ-020 and REQ-022.
REQ-033 Without HANDSHAKE_MONITOR_ASSERT_EN, no assertions SHALL be compiled; flag and counter behaviour SHALL be identical in both builds.

Verification
REQ-034 Defaults; ch0 valid=1, ready=1 for 5 cycles -> xfer_count ch0 = 5; all error flags 0.
REQ-035 ch1 valid=1, data=0xA, ready=0 for 2 cycles, then valid=0 -> err_valid_drop=3'b010 and any_err=1 the next cycle; flag holds until err_clr.
REQ-036 ch2 valid=1, ready=0, data 0x3 then 0x4 -> err_data_change=3'b100; ready=1 with data=0x3 -> xfer_count ch2 = 1.
REQ-037 STALL_LIMIT=4; ch0 valid=1, ready=0 for 10 cycles -> err_stall[0] rises on the 4th stalled edge and no further events occur.
REQ-038 CNT_WIDTH=8; 257 back-to-back transfers on ch1 -> xfer_count ch1 = 1, no error flags set.
REQ-039 err_clr=1 on the same edge as a ch0 valid drop -> err_valid_drop[0]=1 and the other flags are cleared; RESET mid-stall -> all outputs 0 the next cycle.
